prog_loader: RTL and testbench

//  Write-side initiator for the word-aligned instruction/data memories: fills RAM from a byte stream.

---
 rtl/prog_loader_if.sv | 42 ++++
 rtl/prog_loader.sv | 202 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// ----------------------------------------------------------------------------
// prog_loader_if
//   Groups the byte-stream handshake and the memory write port of the program
//   loader.
//   slave  : loader side. It sinks the byte stream and drives the memory write
//            port.
//   master : environment side. It sources the bytes and observes the writes.
// Signals
//   in_valid   byte stream valid
//   in_data    byte stream data, least-significant byte of each word first
//   in_ready   loader accepts the byte this cycle (transfer = in_valid & in_ready)
//   MemWrite   single-cycle write strobe, one per word
//   DataAdr    byte address of the write
//   WriteData  assembled 32-bit word
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output MemWrite,
        output DataAdr,
        output WriteData
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  MemWrite,
        input  DataAdr,
        input  WriteData
    );
endinterface

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//   Write-side initiator that fills a word-aligned RAM from a little-endian
//   byte stream. Four accepted bytes form one 32-bit word. Each word is issued
//   as a single-cycle write at incrementing word addresses. The core is held in
//   reset until a load completes.
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high
//   start      one-cycle load request, only looked at in IDLE
//   num_words  number of words to load, sampled together with start
//   bus        prog_loader_if.slave: byte stream in, memory write port out
//   core_hold  1 holds the core in reset
//   busy       load in progress (RECV or WRITE)
//   done       one-cycle pulse when a load finishes
//   err        one-cycle pulse when start is rejected (num_words > DEPTH_WORDS)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module prog_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          CNT_W       = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    prog_loader_if.slave      bus,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    // Registered state and outputs
    state_t             state_r;
    logic [1:0]         byte_cnt_r;
    logic [CNT_W-1:0]   word_idx_r;
    logic [CNT_W-1:0]   num_words_r;
    logic [31:0]        word_r;
    logic [31:0]        dataadr_r;
    logic [31:0]        wdata_r;
    logic               in_ready_r;
    logic               memwrite_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               hold_r;

    // Next-cycle values
    state_t             state_s;
    logic [1:0]         byte_cnt_s;
    logic [CNT_W-1:0]   word_idx_s;
    logic [CNT_W-1:0]   num_words_s;
    logic [31:0]        word_s;
    logic [31:0]        dataadr_s;
    logic [31:0]        wdata_s;
    logic               in_ready_s;
    logic               memwrite_s;
    logic               busy_s;
    logic               done_s;
    logic               err_s;
    logic               hold_s;
    logic               xfer_s;

    // in_ready_r is a register, so the handshake never has an
    // in_valid -> in_ready combinational path.
    assign xfer_s = bus.in_valid & in_ready_r;

    // Next-state and next-output decode
    always_comb begin
        state_s     = state_r;
        byte_cnt_s  = byte_cnt_r;
        word_idx_s  = word_idx_r;
        num_words_s = num_words_r;
        word_s      = word_r;
        dataadr_s   = dataadr_r;
        wdata_s     = wdata_r;
        hold_s      = hold_r;
        err_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (num_words > DEPTH_C) begin
                        // Rejected request: core_hold is left untouched
                        err_s = 1'b1;
                    end else if (num_words == ZERO_C) begin
                        state_s = DONE;
                        hold_s  = 1'b0;
                    end else begin
                        state_s     = RECV;
                        num_words_s = num_words;
                        word_idx_s  = ZERO_C;
                        byte_cnt_s  = 2'd0;
                        word_s      = 32'h0000_0000;
                        hold_s      = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            RECV: begin
                if (xfer_s) begin
                    word_s[{byte_cnt_r, 3'b000} +: 8] = bus.in_data;
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        // Present the complete word, including the byte
                        // arriving now, during the WRITE cycle.
                        state_s   = WRITE;
                        dataadr_s = BASE_ADDR + 32'({word_idx_r, 2'b00});
                        wdata_s   = word_s;
                    end else begin
                        state_s = RECV;
                    end
                end else begin
                    state_s = RECV;
                end
            end

            WRITE: begin
                if (word_idx_r == (num_words_r - ONE_C)) begin
                    state_s = DONE;
                    hold_s  = 1'b0;
                end else begin
                    state_s    = RECV;
                    word_idx_s = word_idx_r + ONE_C;
                end
            end

            DONE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs that depend only on the state are registered as a decode of
        // the next state, so they line up with the state register.
        in_ready_s = (state_s == RECV);
        memwrite_s = (state_s == WRITE);
        busy_s     = (state_s == RECV) || (state_s == WRITE);
        done_s     = (state_s == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            byte_cnt_r  <= 2'd0;
            word_idx_r  <= ZERO_C;
            num_words_r <= ZERO_C;
            word_r      <= 32'h0000_0000;
            dataadr_r   <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            in_ready_r  <= 1'b0;
            memwrite_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            hold_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            byte_cnt_r  <= byte_cnt_s;
            word_idx_r  <= word_idx_s;
            num_words_r <= num_words_s;
            word_r      <= word_s;
            dataadr_r   <= dataadr_s;
            wdata_r     <= wdata_s;
            in_ready_r  <= in_ready_s;
            memwrite_r  <= memwrite_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            hold_r      <= hold_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.MemWrite  = memwrite_r;
    assign bus.DataAdr   = dataadr_r;
    assign bus.WriteData = wdata_r;
    assign core_hold     = hold_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] num_words;
    logic       core_hold, busy, done, err;

    prog_loader_if bus ();

    prog_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .bus       (bus.slave),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor of the DUT's observable events, sampled on the falling edge
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int acc_cnt  = 0;

    always @(negedge clk) begin
        if (bus.MemWrite) begin
            wr_adr.push_back(bus.DataAdr);
            wr_dat.push_back(bus.WriteData);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (bus.in_valid && bus.in_ready) acc_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Offer one byte and wait (bounded) until it is accepted; in_valid stays high
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("byte_accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [6:0] n);
        start = 1'b1;
        num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
        num_words = 7'd0;
    endtask

    typedef struct {
        logic        st;
        logic [6:0]  nw;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        dn;
        logic        er;
        logic        bsy;
        logic        hold;
    } vec_t;

    function automatic vec_t mk(logic st, logic [6:0] nw, logic v, logic [7:0] d,
                                logic rdy, logic we, logic [31:0] adr, logic [31:0] wd,
                                logic dn, logic er, logic bsy, logic hold);
        vec_t r;
        r.st = st; r.nw = nw; r.v = v; r.d = d; r.rdy = rdy; r.we = we;
        r.adr = adr; r.wd = wd; r.dn = dn; r.er = er; r.bsy = bsy; r.hold = hold;
        return r;
    endfunction

    vec_t vecs[12];

    initial begin
        int wr0, dn0, er0, ac0;
        logic [31:0] exp_w;

        // Two-word load, back-to-back bytes; each row is the input for one
        // cycle and the outputs expected just after the following edge.
        vecs[0]  = mk(1'b1, 7'd2, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1);
        vecs[1]  = mk(1'b0, 7'd0, 1'b1, 8'h78, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1);
        vecs[2]  = mk(1'b0, 7'd0, 1'b1, 8'h56, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1);
        vecs[3]  = mk(1'b0, 7'd0, 1'b1, 8'h34, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1);
        vecs[4]  = mk(1'b0, 7'd0, 1'b1, 8'h12, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[5]  = mk(1'b0, 7'd0, 1'b1, 8'hEF, 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 7'd0, 1'b1, 8'hEF, 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(1'b0, 7'd0, 1'b1, 8'hBE, 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[8]  = mk(1'b0, 7'd0, 1'b1, 8'hAD, 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[9]  = mk(1'b0, 7'd0, 1'b1, 8'hDE, 1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[10] = mk(1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);

        reset = 1'b1; start = 1'b0; num_words = 7'd0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_hold", {31'd0, core_hold},    32'd1);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_memwrite",  {31'd0, bus.MemWrite}, 32'd0);
        chk("rst_done",      {31'd0, done},         32'd0);
        chk("rst_err",       {31'd0, err},          32'd0);
        chk("rst_busy",      {31'd0, busy},         32'd0);
        chk("rst_dataadr",   bus.DataAdr,           32'h0);
        chk("rst_wdata",     bus.WriteData,         32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven two-word load
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].st; num_words = vecs[i].nw;
            bus.in_valid = vecs[i].v; bus.in_data = vecs[i].d;
            @(posedge clk); #1;
            chk($sformatf("v%0d_in_ready", i),  {31'd0, bus.in_ready}, {31'd0, vecs[i].rdy});
            chk($sformatf("v%0d_memwrite", i),  {31'd0, bus.MemWrite}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_dataadr", i),   bus.DataAdr,           vecs[i].adr);
            chk($sformatf("v%0d_wdata", i),     bus.WriteData,         vecs[i].wd);
            chk($sformatf("v%0d_done", i),      {31'd0, done},         {31'd0, vecs[i].dn});
            chk($sformatf("v%0d_err", i),       {31'd0, err},          {31'd0, vecs[i].er});
            chk($sformatf("v%0d_busy", i),      {31'd0, busy},         {31'd0, vecs[i].bsy});
            chk($sformatf("v%0d_core_hold", i), {31'd0, core_hold},    {31'd0, vecs[i].hold});
        end
        start = 1'b0; bus.in_valid = 1'b0;

        // One word with gaps, valid held high through WRITE
        wr0 = wr_adr.size(); ac0 = acc_cnt;
        pulse_start(7'd1);
        chk("t3_hold_after_start", {31'd0, core_hold}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            if (k == 0) chk("t3_busy_idle_gap", {31'd0, busy}, 32'd1);
            send_byte(8'(8'h11 * (k + 1)));
        end
        bus.in_data = 8'h99;
        chk("t3_write_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t3_write_strobe",   {31'd0, bus.MemWrite}, 32'd1);
        chk("t3_write_data",     bus.WriteData,         32'h44332211);
        chk("t3_write_adr",      bus.DataAdr,           32'h0);
        @(posedge clk); #1;
        chk("t3_done",           {31'd0, done},         32'd1);
        chk("t3_hold_released",  {31'd0, core_hold},    32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("t3_bytes_consumed", 32'(acc_cnt - ac0),    32'd4);
        chk("t3_write_count",    32'(wr_adr.size() - wr0), 32'd1);

        // Zero-word load and rejected oversize load
        wr0 = wr_adr.size(); er0 = err_cnt;
        pulse_start(7'd0);
        chk("t4_zero_done",  {31'd0, done},         32'd1);
        chk("t4_zero_busy",  {31'd0, busy},         32'd0);
        @(posedge clk); #1;
        chk("t4_zero_done_pulse", {31'd0, done},    32'd0);
        pulse_start(7'd65);
        chk("t4_err",        {31'd0, err},          32'd1);
        chk("t4_err_busy",   {31'd0, busy},         32'd0);
        chk("t4_err_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("t4_err_hold",   {31'd0, core_hold},    32'd0);
        @(posedge clk); #1;
        chk("t4_err_pulse",  {31'd0, err},          32'd0);
        chk("t4_err_count",  32'(err_cnt - er0),    32'd1);
        chk("t4_no_writes",  32'(wr_adr.size() - wr0), 32'd0);

        // Reset in the middle of a three-word load
        wr0 = wr_adr.size();
        pulse_start(7'd3);
        for (int k = 1; k <= 6; k++) send_byte(8'(k));
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_hold",     {31'd0, core_hold},    32'd1);
        chk("t5_rst_ready",    {31'd0, bus.in_ready}, 32'd0);
        chk("t5_rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        chk("t5_rst_busy",     {31'd0, busy},         32'd0);
        chk("t5_rst_adr",      bus.DataAdr,           32'h0);
        chk("t5_rst_wdata",    bus.WriteData,         32'h0);
        reset = 1'b0;
        chk("t5_write_count",  32'(wr_adr.size() - wr0), 32'd1);
        if (wr_adr.size() > wr0) chk("t5_word0_data", wr_dat[wr0], 32'h04030201);
        @(posedge clk); #1;
        wr0 = wr_adr.size();
        pulse_start(7'd1);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        bus.in_valid = 1'b0;
        wait_done();
        chk("t5_reload_count", 32'(wr_adr.size() - wr0), 32'd1);
        if (wr_adr.size() > wr0) begin
            chk("t5_reload_adr",  wr_adr[wr0], 32'h0);
            chk("t5_reload_data", wr_dat[wr0], 32'hD4C3B2A1);
        end

        // Full-depth load with a stray start pulse in the middle
        wr0 = wr_adr.size(); dn0 = done_cnt;
        pulse_start(7'd64);
        for (int w = 0; w < 64; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (w == 10 && k == 2) begin
                    start = 1'b1;
                    num_words = 7'd5;
                end
                send_byte(8'(w * 4 + k));
                start = 1'b0;
                num_words = 7'd0;
            end
        end
        bus.in_valid = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("t6_write_count", 32'(wr_adr.size() - wr0), 32'd64);
        chk("t6_done_count",  32'(done_cnt - dn0),      32'd1);
        chk("t6_hold_final",  {31'd0, core_hold},       32'd0);
        if (wr_adr.size() - wr0 == 64) begin
            for (int w = 0; w < 64; w++) begin
                exp_w = {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)};
                chk($sformatf("t6_adr_%0d", w), wr_adr[wr0 + w], 32'(w * 4));
                chk($sformatf("t6_dat_%0d", w), wr_dat[wr0 + w], exp_w);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
